// File: rtl/sort_controller.sv
// sort_controller: loads N bytes, bubble-sorts them through an external comparator, streams them out ascending
module sort_controller #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  input  logic         start,
  output logic [W-1:0] cmp_a,
  output logic [W-1:0] cmp_b,
  input  logic         cmp_less,
  input  logic         cmp_equal,
  input  logic         cmp_greater,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready,
  output logic         busy,
  output logic         sorted
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(N + 1);
  typedef enum logic [1:0] {IDLE, SORT, OUT} state_t;
  state_t r_state, w_next;
  logic [W-1:0]  r_buf [N];
  logic [CW-1:0] r_count;
  logic [IW-1:0] r_i, r_pass, r_rd;
  logic          r_swapped, r_sorted;
  logic [IW-1:0] w_ip1;
  logic          w_full, w_last_cmp, w_done, w_last_out, w_unused;
  assign w_ip1      = r_i + IW'(1);
  assign w_full     = r_count == CW'(N);
  assign w_last_cmp = r_i == IW'(N - 2);
  assign w_done     = w_last_cmp && (!(r_swapped | cmp_greater) || r_pass == IW'(N - 2));
  assign w_last_out = r_rd == IW'(N - 1);
  // only the greater flag decides a swap; the other flags are intentionally ignored
  assign w_unused   = cmp_less ^ cmp_equal;
  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end
  // next-state: start needs a full buffer, sort ends on the last pass edge, output ends on the last transfer
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    w_next = (start && w_full) ? SORT : IDLE;
      SORT:    w_next = w_done ? OUT : SORT;
      OUT:     w_next = (out_ready && w_last_out) ? IDLE : OUT;
      default: w_next = IDLE;
    endcase
  end
  // outputs: operands only visible while sorting, data only visible while streaming
  always_comb begin
    in_ready  = (r_state == IDLE) && !w_full;
    busy      = r_state != IDLE;
    out_valid = r_state == OUT;
    out_data  = (r_state == OUT) ? r_buf[r_rd] : '0;
    cmp_a     = (r_state == SORT) ? r_buf[r_i] : '0;
    cmp_b     = (r_state == SORT) ? r_buf[w_ip1] : '0;
    sorted    = r_sorted;
  end
  // datapath: buffer load, compare-and-swap walk, read pointer; indices rearm while idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N; k++) r_buf[k] <= '0;
      r_count   <= '0;
      r_i       <= '0;
      r_pass    <= '0;
      r_rd      <= '0;
      r_swapped <= 1'b0;
      r_sorted  <= 1'b0;
    end else begin
      r_sorted <= (r_state == SORT) && w_done;
      unique case (r_state)
        IDLE: begin
          if (in_valid && !w_full) begin
            r_buf[r_count[IW-1:0]] <= in_data;
            r_count                <= r_count + CW'(1);
          end
          r_i       <= '0;
          r_pass    <= '0;
          r_rd      <= '0;
          r_swapped <= 1'b0;
        end
        SORT: begin
          if (cmp_greater) begin
            r_buf[r_i]   <= r_buf[w_ip1];
            r_buf[w_ip1] <= r_buf[r_i];
          end
          r_swapped <= (r_swapped | cmp_greater) & !w_last_cmp;
          r_i       <= w_last_cmp ? '0 : w_ip1;
          r_pass    <= w_last_cmp ? r_pass + IW'(1) : r_pass;
        end
        OUT: begin
          if (out_ready) begin
            r_rd <= r_rd + IW'(1);
            if (w_last_out) r_count <= '0;
          end
        end
        default: r_count <= '0;
      endcase
    end
  end
endmodule

// File: tb/tb_sort_controller.sv
// tb_sort_controller: directed tests of the bubble-sort sequencer with a behavioural comparator
module tb_sort_controller;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_ready;
  logic       start = 1'b0;
  logic [7:0] cmp_a, cmp_b;
  logic       cmp_less, cmp_equal, cmp_greater;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready = 1'b0;
  logic       busy, sorted;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign cmp_less    = cmp_a < cmp_b;
  assign cmp_equal   = cmp_a == cmp_b;
  assign cmp_greater = cmp_a > cmp_b;

  sort_controller #(.N(4), .W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .start(start), .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_less(cmp_less), .cmp_equal(cmp_equal),
    .cmp_greater(cmp_greater), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .sorted(sorted)
  );

  task automatic load_one(input logic [7:0] v);
    in_valid = 1'b1;
    in_data  = v;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic load4(input logic [7:0] a, b, c, d);
    load_one(a); load_one(b); load_one(c); load_one(d);
  endtask

  task automatic run_sort(output int cyc, output logic sorted_at_entry);
    int guard = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!out_valid && guard < 100) begin
      if (busy) cyc++;
      guard++;
      @(negedge clk);
    end
    sorted_at_entry = sorted;
  endtask

  task automatic drain(input int hold, output logic [7:0] o0, o1, o2, o3,
                       output int hold_bad, output int sorted_cnt, output int busy_low);
    logic [7:0] o [4];
    logic [7:0] h0;
    hold_bad = 0; sorted_cnt = 0; busy_low = 0;
    h0 = out_data;
    out_ready = 1'b0;
    for (int k = 0; k < hold; k++) begin
      if (out_data !== h0 || !out_valid) hold_bad++;
      sorted_cnt += int'(sorted);
      @(negedge clk);
    end
    for (int k = 0; k < 4; k++) begin
      out_ready = 1'b1;
      o[k] = out_data;
      sorted_cnt += int'(sorted);
      busy_low += int'(!busy || !out_valid);
      @(negedge clk);
    end
    out_ready = 1'b0;
    o0 = o[0]; o1 = o[1]; o2 = o[2]; o3 = o[3];
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    tests++; if (out_data !== 8'd0) begin fails++; $display("FAIL reset_out_data got %0d want 0", out_data); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    tests++; if (sorted !== 1'b0) begin fails++; $display("FAIL reset_sorted got %b want 0", sorted); end
    tests++; if (cmp_a !== 8'd0 || cmp_b !== 8'd0) begin fails++; $display("FAIL reset_cmp got %0d/%0d want 0/0", cmp_a, cmp_b); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_unsorted;
    int cyc, hb, sc, bl; logic se; logic [7:0] o0, o1, o2, o3;
    load4(8'd120, 8'd8, 8'd250, 8'd7);
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL unsorted_full_in_ready got %b want 0", in_ready); end
    run_sort(cyc, se);
    tests++; if (cyc != 9) begin fails++; $display("FAIL unsorted_cycles got %0d want 9", cyc); end
    tests++; if (se !== 1'b1) begin fails++; $display("FAIL unsorted_sorted_entry got %b want 1", se); end
    drain(0, o0, o1, o2, o3, hb, sc, bl);
    tests++; if ({o0, o1, o2, o3} !== {8'd7, 8'd8, 8'd120, 8'd250}) begin fails++; $display("FAIL unsorted_data got %0d,%0d,%0d,%0d want 7,8,120,250", o0, o1, o2, o3); end
    tests++; if (sc != 1) begin fails++; $display("FAIL unsorted_sorted_pulses got %0d want 1", sc); end
    tests++; if (bl != 0) begin fails++; $display("FAIL unsorted_busy_out got %0d low cycles want 0", bl); end
    tests++; if (busy !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL unsorted_return got busy=%b in_ready=%b want 0/1", busy, in_ready); end
  endtask

  task automatic test_already_sorted;
    int cyc, hb, sc, bl; logic se; logic [7:0] o0, o1, o2, o3;
    load4(8'd1, 8'd2, 8'd3, 8'd4);
    run_sort(cyc, se);
    tests++; if (cyc != 3) begin fails++; $display("FAIL presorted_cycles got %0d want 3", cyc); end
    drain(0, o0, o1, o2, o3, hb, sc, bl);
    tests++; if ({o0, o1, o2, o3} !== {8'd1, 8'd2, 8'd3, 8'd4}) begin fails++; $display("FAIL presorted_data got %0d,%0d,%0d,%0d want 1,2,3,4", o0, o1, o2, o3); end
  endtask

  task automatic test_reverse;
    int cyc, hb, sc, bl; logic se; logic [7:0] o0, o1, o2, o3;
    load4(8'd4, 8'd3, 8'd2, 8'd1);
    run_sort(cyc, se);
    tests++; if (cyc != 9) begin fails++; $display("FAIL reverse_cycles got %0d want 9", cyc); end
    drain(0, o0, o1, o2, o3, hb, sc, bl);
    tests++; if ({o0, o1, o2, o3} !== {8'd1, 8'd2, 8'd3, 8'd4}) begin fails++; $display("FAIL reverse_data got %0d,%0d,%0d,%0d want 1,2,3,4", o0, o1, o2, o3); end
  endtask

  task automatic test_unsigned_equal;
    int cyc, hb, sc, bl; logic se; logic [7:0] o0, o1, o2, o3;
    load4(8'd0, 8'd251, 8'd251, 8'd5);
    run_sort(cyc, se);
    tests++; if (cyc != 9) begin fails++; $display("FAIL unsigned_cycles got %0d want 9", cyc); end
    drain(0, o0, o1, o2, o3, hb, sc, bl);
    tests++; if ({o0, o1, o2, o3} !== {8'd0, 8'd5, 8'd251, 8'd251}) begin fails++; $display("FAIL unsigned_data got %0d,%0d,%0d,%0d want 0,5,251,251", o0, o1, o2, o3); end
  endtask

  task automatic test_early_start_backpressure;
    int cyc, hb, sc, bl; logic se; logic [7:0] o0, o1, o2, o3;
    load_one(8'd5); load_one(8'd2);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tests++; if (busy !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL early_start got busy=%b in_ready=%b want 0/1", busy, in_ready); end
    load_one(8'd9); load_one(8'd1);
    run_sort(cyc, se);
    tests++; if (cyc != 9) begin fails++; $display("FAIL early_cycles got %0d want 9", cyc); end
    tests++; if (out_data !== 8'd1) begin fails++; $display("FAIL early_first_out got %0d want 1", out_data); end
    drain(3, o0, o1, o2, o3, hb, sc, bl);
    tests++; if (hb != 0) begin fails++; $display("FAIL early_hold got %0d unstable cycles want 0", hb); end
    tests++; if (sc != 1) begin fails++; $display("FAIL early_sorted_pulses got %0d want 1", sc); end
    tests++; if ({o0, o1, o2, o3} !== {8'd1, 8'd2, 8'd5, 8'd9}) begin fails++; $display("FAIL early_data got %0d,%0d,%0d,%0d want 1,2,5,9", o0, o1, o2, o3); end
  endtask

  task automatic test_reset_mid_sort;
    int cyc, hb, sc, bl; logic se; logic [7:0] o0, o1, o2, o3;
    load4(8'd40, 8'd30, 8'd20, 8'd10);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    tests++; if (busy !== 1'b1 || cmp_a === 8'd0) begin fails++; $display("FAIL midsort_pre got busy=%b cmp_a=%0d want 1/nonzero", busy, cmp_a); end
    rst = 1'b1;
    #1;
    tests++; if (busy !== 1'b0 || out_valid !== 1'b0) begin fails++; $display("FAIL midsort_async got busy=%b out_valid=%b want 0/0", busy, out_valid); end
    tests++; if (cmp_a !== 8'd0 || cmp_b !== 8'd0) begin fails++; $display("FAIL midsort_cmp got %0d/%0d want 0/0", cmp_a, cmp_b); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL midsort_in_ready got %b want 1", in_ready); end
    load4(8'd3, 8'd1, 8'd2, 8'd0);
    run_sort(cyc, se);
    tests++; if (cyc != 9) begin fails++; $display("FAIL midsort_cycles got %0d want 9", cyc); end
    drain(0, o0, o1, o2, o3, hb, sc, bl);
    tests++; if ({o0, o1, o2, o3} !== {8'd0, 8'd1, 8'd2, 8'd3}) begin fails++; $display("FAIL midsort_data got %0d,%0d,%0d,%0d want 0,1,2,3", o0, o1, o2, o3); end
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_unsorted;
    test_already_sorted;
    test_reverse;
    test_unsigned_equal;
    test_early_start_backpressure;
    test_reset_mid_sort;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sort_controller.md
# sort_controller

Sequencer that owns the shared 8-bit magnitude comparator (`comparator_8`) and uses it to bubble-sort a small on-chip buffer of unsigned bytes. The block serially loads N values, runs compare-and-swap passes at one comparison per clock, and then streams the values out in ascending order. It sits between the input byte stream and the downstream consumer, and it is the only driver of the comparator's `a`/`b` inputs.

## Interface
- `N`, default 4: number of elements per sort. N ≥ 2. Index width is $clog2(N).
- `W`, default 8: element width. This must match the comparator width.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: load data valid.
- `in_data` in W: element to load.
- `in_ready` out 1: buffer can accept an element.
- `start` in 1: request a sort of the loaded buffer.
- `cmp_a` out W: comparator operand a = buf[i].
- `cmp_b` out W: comparator operand b = buf[i+1].
- `cmp_less`, `cmp_equal`, `cmp_greater` in 1 each: comparator results (combinational, same cycle).
- `out_valid` out 1: sorted element valid.
- `out_data` out W: sorted element.
- `out_ready` in 1: consumer accepts the element.
- `busy` out 1: high in SORT and OUT.
- `sorted` out 1: one-cycle pulse on entry to OUT.

## Operation
- **States:** IDLE, SORT, OUT.
- **IDLE:**
  - `in_ready` = (count < N).
  - When `in_valid && in_ready`, write buf[count] = `in_data` and increment count.
  - When `start` is asserted and count == N, go to SORT with i=0, pass=0, swapped=0.
  - When count < N, `start` is ignored. No error is raised and loading continues.
- **SORT:** performs one comparison per cycle on buf[i] vs buf[i+1].
  - If `cmp_greater`, swap the two entries at the clock edge and set swapped=1.
  - Equal values never swap, so the sort is stable.
  - Only `cmp_greater` is decoded. Any other flag combination, including illegal ones, means no swap.
  - i increments. At i == N-2 the pass ends and pass increments.
  - At pass end, if swapped == 0 or pass+1 == N-1, go to OUT. Otherwise start a new pass with i=0 and swapped=0.
- **OUT:**
  - `out_valid` = 1 and `out_data` = buf[rd] with rd starting at 0.
  - Each `out_valid && out_ready` advances rd.
  - The transfer at rd == N-1 returns the block to IDLE with count=0.
  - `out_data` holds steady while `out_ready` = 0.
- **Comparison semantics:** comparison is unsigned. A value written as -5 in 8 bits is 251 and sorts above 0.
- **Operand outputs:** `cmp_a`/`cmp_b` equal buf[i]/buf[i+1] in SORT and 0 in all other states.

## Timing
- **Reset values:**
  - State IDLE; count, i, pass, rd, swapped = 0; buf cleared to 0.
  - `in_ready`=1, `out_valid`=0, `out_data`=0, `busy`=0, `sorted`=0, `cmp_a`=`cmp_b`=0.
- **Reset mid-operation:** reset in any state applies the reset values immediately (asynchronous). Buffer contents are lost.
- **Load:** one element per cycle maximum. `in_ready` drops the cycle after the Nth write.
- **Start:** `start` sampled in IDLE with count==N means SORT in the next cycle. The `busy` rise is registered.
- **Sort cycles:**
  - Each pass takes exactly N-1 cycles.
  - Already-sorted input takes N-1 SORT cycles.
  - Worst case takes (N-1)² cycles.
- **Entry to OUT:** the transition occurs on the edge ending the final pass.
  - `sorted` is high for exactly the first OUT cycle.
  - `out_valid` rises in the same cycle.
- **Output throughput:** one element per cycle when `out_ready` is held high, so OUT lasts N cycles minimum.
- **Input during SORT/OUT:** `in_valid` is ignored because `in_ready`=0. `start` is ignored outside IDLE.
- **Return to IDLE:** the cycle after the last output transfer, with `in_ready`=1 and `busy`=0.

## Test plan
- **Unsorted input:** N=4, load 120,8,250,7, then start.
  - Output must be 7,8,120,250.
  - `sorted` pulses once.
  - `busy` is high from the first SORT cycle through the last OUT transfer.
- **Already sorted:** load 1,2,3,4, then start.
  - SORT lasts exactly 3 cycles with no swaps.
  - Output is 1,2,3,4.
- **Reverse order:** load 4,3,2,1, then start.
  - SORT lasts exactly 9 cycles.
  - Output is 1,2,3,4.
- **Unsigned and equal values:** load 0,251,251,5 (251 = -5 as 8 bits).
  - Output must be 0,5,251,251.
  - `cmp_a`/`cmp_b` are never swapped on equal values.
- **Early start and backpressure:** load only 2 elements, pulse `start`.
  - The block stays in IDLE with `in_ready`=1.
  - Load 2 more and start. In OUT, hold `out_ready`=0 for 3 cycles: `out_data` must stay at the smallest value.
- **Reset mid-sort:** assert `rst` during the second SORT cycle.
  - `busy`=0, `out_valid`=0, `cmp_a`=`cmp_b`=0 immediately.
  - After release, `in_ready`=1 and a fresh load/sort completes correctly.
